seq_pattern_tx: RTL

//  Serial bit-pattern transmitter: emits a PAT_W-bit pattern MSB-first on a 1-bit line, one bit per clk.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_pattern_tx_if.sv | 25 ++
 rtl/seq_bit_counter.sv | 28 ++
 rtl/seq_pattern_tx.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter slice.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] PAT_DEFAULT = 8'b00100011;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/serial bundle between a controlling FSM and seq_pattern_tx.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 8,
  parameter int REP_W = 4
);
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic             start;
  logic [REP_W-1:0] rep;
  logic             abort;
  logic             x_out;
  logic             sof;
  logic             busy;
  logic             done;

  modport master (
    output load, pat_in, start, rep, abort,
    input  x_out, sof, busy, done
  );

  modport slave (
    input  load, pat_in, start, rep, abort,
    output x_out, sof, busy, done
  );
endinterface

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module seq_bit_counter
  import seq_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Count register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: MSB-first frames, idle-'1' gaps between
// repeats, abort, and a one-cycle done pulse. All outputs are registered.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PAT_DEFAULT),
  parameter int               GAP     = 2,
  parameter int               REP_W   = 4
) (
  input logic             clk,
  input logic             reset,
  seq_pattern_tx_if.slave bus
);

  localparam int CW     = $clog2(PAT_W);
  localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_reg, pat_n;
  logic [REP_W-1:0] frames, frames_n;
  logic             x_n, sof_n, busy_n, done_n;

  logic          bit_ld, bit_dec, bit_zero;
  logic [CW-1:0] bit_cnt;
  logic          gap_ld, gap_dec, gap_zero;
  logic [GW-1:0] gap_cnt;

  // bit_cnt is the index of the bit currently on x_out, so the next bit
  // fetched is bit_cnt-1 and bit_zero marks the last bit of a frame.
  seq_bit_counter #(.W(CW)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (bit_ld),
    .load_val (CW'(PAT_W - 1)),
    .dec      (bit_dec),
    .count    (bit_cnt),
    .zero     (bit_zero)
  );

  // gap_cnt counts remaining gap cycles after the current one.
  seq_bit_counter #(.W(GW)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_ld),
    .load_val (GW'(GAP_M1)),
    .dec      (gap_dec),
    .count    (gap_cnt),
    .zero     (gap_zero)
  );

  // Next-state and next-output decode; defaults give the idle line level.
  always_comb begin
    state_n  = state;
    pat_n    = pat_reg;
    frames_n = frames;
    x_n      = 1'b1;
    sof_n    = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    bit_ld   = 1'b0;
    bit_dec  = 1'b0;
    gap_ld   = 1'b0;
    gap_dec  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.load)
          pat_n = bus.pat_in;
        if (bus.start && !bus.abort) begin
          frames_n = (bus.rep == '0) ? REP_W'(1) : bus.rep;
          state_n  = ST_SEND;
          x_n      = pat_n[PAT_W-1];
          sof_n    = 1'b1;
          busy_n   = 1'b1;
          bit_ld   = 1'b1;
        end
      end

      ST_SEND: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
        end else if (!bit_zero) begin
          x_n     = pat_reg[bit_cnt - CW'(1)];
          busy_n  = 1'b1;
          bit_dec = 1'b1;
        end else if (frames > REP_W'(1)) begin
          frames_n = frames - REP_W'(1);
          busy_n   = 1'b1;
          if (GAP == 0) begin
            x_n    = pat_reg[PAT_W-1];
            sof_n  = 1'b1;
            bit_ld = 1'b1;
          end else begin
            state_n = ST_GAP;
            gap_ld  = 1'b1;
          end
        end else begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end
      end

      ST_GAP: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
        end else if (!gap_zero) begin
          busy_n  = 1'b1;
          gap_dec = 1'b1;
        end else begin
          state_n = ST_SEND;
          x_n     = pat_reg[PAT_W-1];
          sof_n   = 1'b1;
          busy_n  = 1'b1;
          bit_ld  = 1'b1;
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, pattern, frame counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pat_reg   <= PATTERN;
      frames    <= '0;
      bus.x_out <= 1'b1;
      bus.sof   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      state     <= state_n;
      pat_reg   <= pat_n;
      frames    <= frames_n;
      bus.x_out <= x_n;
      bus.sof   <= sof_n;
      bus.busy  <= busy_n;
      bus.done  <= done_n;
    end
  end

endmodule
